// File: rtl/div_shift_seq.sv
// div_shift_seq: sequential restoring shift-subtract divider, one quotient
// bit per clock. Takes a valid/ready operand pair, iterates DW times, then
// presents a registered result with a one-cycle O_VALID pulse. Signed mode
// divides magnitudes and fixes the signs at the end (truncation toward zero,
// remainder follows the dividend). Divide-by-zero and the signed
// most-negative / -1 case are flagged and forced to fixed result values.
module div_shift_seq #(
    parameter int DW = 32,
    parameter int CW = 6
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic          I_VALID,
    input  logic          I_SIGNED,
    input  logic [DW-1:0] I_DIVIDEND,
    input  logic [DW-1:0] I_DIVISOR,
    output logic          O_READY,
    output logic          O_VALID,
    output logic [DW-1:0] O_QUOT,
    output logic [DW-1:0] O_REM,
    output logic          O_DIV0,
    output logic          O_OVF
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    state_t state;
    state_t state_next;

    // Working registers. The partial remainder and partial quotient only
    // need DW-1 bits between iterations: after iteration i the remainder is
    // below 2^(i+1), so its top bit is always zero until the final step,
    // and the final step feeds the output registers directly.
    logic [CW-1:0] count;
    logic [DW-1:0] dvd_sh;       // dividend magnitude, consumed MSB first
    logic [DW-1:0] dvs_mag;      // divisor magnitude
    logic [DW-1:0] dvd_raw;      // untouched dividend, returned on divide-by-zero
    logic [DW-2:0] rem_q;        // partial remainder
    logic [DW-2:0] quot_q;       // quotient bits collected so far
    logic          neg_quot;     // operand signs differ (signed mode)
    logic          neg_rem;      // dividend negative (signed mode)
    logic          div0_flag;
    logic          ovf_flag;

    // Handshake and sequencing decodes.
    logic accept;
    logic last_iter;

    // Operand preparation at accept.
    logic          dvd_neg_in;
    logic          dvs_neg_in;
    logic [DW-1:0] dvd_mag_in;
    logic [DW-1:0] dvs_mag_in;

    // One restoring step.
    logic [DW-1:0] shifted;
    logic [DW:0]   trial;
    logic          q_bit;
    logic [DW-1:0] rem_step;
    logic [DW-1:0] quot_step;

    // Final result after sign correction and special-case override.
    logic [DW-1:0] quot_signed;
    logic [DW-1:0] rem_signed;
    logic [DW-1:0] quot_final;
    logic [DW-1:0] rem_final;

    assign accept    = (state == ST_IDLE) && I_VALID;
    assign last_iter = (state == ST_CALC) && (count == LAST_CNT);

    assign O_READY = (state == ST_IDLE);
    assign O_VALID = (state == ST_DONE);

    assign dvd_neg_in = I_SIGNED & I_DIVIDEND[DW-1];
    assign dvs_neg_in = I_SIGNED & I_DIVISOR[DW-1];
    assign dvd_mag_in = dvd_neg_in ? (~I_DIVIDEND + 1'b1) : I_DIVIDEND;
    assign dvs_mag_in = dvs_neg_in ? (~I_DIVISOR + 1'b1) : I_DIVISOR;

    assign shifted   = {rem_q, dvd_sh[DW-1]};
    assign trial     = {1'b0, shifted} - {1'b0, dvs_mag};
    assign q_bit     = ~trial[DW];
    assign rem_step  = q_bit ? trial[DW-1:0] : shifted;
    assign quot_step = {quot_q, q_bit};

    assign quot_signed = neg_quot ? (~quot_step + 1'b1) : quot_step;
    assign rem_signed  = neg_rem  ? (~rem_step + 1'b1)  : rem_step;

    // Special cases take priority over whatever the datapath produced.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        quot_final = quot_signed;
        rem_final  = rem_signed;
        if (div0_flag) begin
            quot_final = '1;
            rem_final  = dvd_raw;
        end else if (ovf_flag) begin
            quot_final = MOST_NEG;
            rem_final  = '0;
        end
    end

    // State register.
    always_ff @(posedge I_CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (I_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> CALC on accept, CALC -> DONE after DW steps,
    // DONE -> IDLE after one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept)    state_next = ST_CALC;
            ST_CALC: if (last_iter) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Working registers: load at accept, one restoring step per CALC edge.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            count     <= '0;
            dvd_sh    <= '0;
            dvs_mag   <= '0;
            dvd_raw   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            div0_flag <= 1'b0;
            ovf_flag  <= 1'b0;
        end else if (accept) begin
            count     <= '0;
            dvd_sh    <= dvd_mag_in;
            dvs_mag   <= dvs_mag_in;
            dvd_raw   <= I_DIVIDEND;
            rem_q     <= '0;
            quot_q    <= '0;
            neg_quot  <= dvd_neg_in ^ dvs_neg_in;
            neg_rem   <= dvd_neg_in;
            div0_flag <= (I_DIVISOR == '0);
            ovf_flag  <= I_SIGNED && (I_DIVIDEND == MOST_NEG) && (I_DIVISOR == '1);
        end else if (state == ST_CALC) begin
            count  <= count + 1'b1;
            dvd_sh <= {dvd_sh[DW-2:0], 1'b0};
            rem_q  <= rem_step[DW-2:0];
            quot_q <= quot_step[DW-2:0];
        end
    end

    // Result registers: written only on the final CALC edge, held otherwise.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            O_QUOT <= '0;
            O_REM  <= '0;
            O_DIV0 <= 1'b0;
            O_OVF  <= 1'b0;
        end else if (last_iter) begin
            O_QUOT <= quot_final;
            O_REM  <= rem_final;
            O_DIV0 <= div0_flag;
            O_OVF  <= ovf_flag & ~div0_flag;
        end
    end

endmodule

// File: tb/tb_div_shift_seq.sv
// Self-checking bench for div_shift_seq: directed and random operands checked
// against an arithmetic reference built on the language's own / and %.
module tb_div_shift_seq;

    localparam int DW = 32;
    localparam int CW = 6;
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          sgn;
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic          ready;
    logic          out_valid;
    logic [DW-1:0] quot;
    logic [DW-1:0] rem;
    logic          div0;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    div_shift_seq #(.DW(DW), .CW(CW)) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_VALID    (valid),
        .I_SIGNED   (sgn),
        .I_DIVIDEND (dvd),
        .I_DIVISOR  (dvs),
        .O_READY    (ready),
        .O_VALID    (out_valid),
        .O_QUOT     (quot),
        .O_REM      (rem),
        .O_DIV0     (div0),
        .O_OVF      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {quotient, remainder, div0, ovf}.
    function automatic logic [2*DW+1:0] ref_div(input logic s, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0]        q;
        logic [DW-1:0]        r;
        logic                 d0;
        logic                 ov;
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        sa = a;
        sb = b;
        d0 = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            d0 = 1'b1;
        end else if (s && a == MOST_NEG && b == '1) begin
            q  = MOST_NEG;
            r  = '0;
            ov = 1'b1;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, d0, ov};
    endfunction

    // Runs one operation from IDLE; checks latency, result, pulse width and hold.
    task automatic do_op(input string name, input logic s, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        logic [2*DW+1:0] exp;
        logic [DW-1:0]   exp_q;
        logic [DW-1:0]   exp_r;
        int              n;
        logic            got;
        logic            rdy_seen;
        exp   = ref_div(s, a, b);
        exp_q = exp[2*DW+1:DW+2];
        exp_r = exp[DW+1:2];
        sgn   = s;
        dvd   = a;
        dvs   = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        n        = 0;
        got      = 1'b0;
        rdy_seen = 1'b0;
        // Scramble inputs and poke I_VALID while busy: none of it may matter.
        while (!got && n < DW + 8) begin
            if (ready) rdy_seen = 1'b1;
            sgn   = 1'($urandom);
            dvd   = $urandom;
            dvs   = $urandom;
            valid = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (out_valid) got = 1'b1;
        end
        valid = 1'b0;
        total++;
        if (!got || n != DW) begin
            bad++;
            $display("FAIL %s latency: got=%0d (seen=%0b) want=%0d", name, n, got, DW);
        end
        total++;
        if (rdy_seen || ready !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_busy: O_READY rose during CALC/DONE", name);
        end
        total++;
        if (quot !== exp_q) begin
            bad++;
            $display("FAIL %s quot: got=%h want=%h", name, quot, exp_q);
        end
        total++;
        if (rem !== exp_r) begin
            bad++;
            $display("FAIL %s rem: got=%h want=%h", name, rem, exp_r);
        end
        total++;
        if (div0 !== exp[1] || ovf !== exp[0]) begin
            bad++;
            $display("FAIL %s flags: got div0=%b ovf=%b want div0=%b ovf=%b",
                     name, div0, ovf, exp[1], exp[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL %s pulse_end: got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid, ready);
        end
        total++;
        if (quot !== exp_q || rem !== exp_r) begin
            bad++;
            $display("FAIL %s hold: got q=%h r=%h want q=%h r=%h", name, quot, rem, exp_q, exp_r);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        valid = 1'b0;
        sgn   = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: got ready=%b valid=%b want ready=1 valid=0", ready, out_valid);
        end
        total++;
        if (quot !== '0 || rem !== '0 || div0 !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got q=%h r=%h d0=%b ov=%b want all 0", quot, rem, div0, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [DW-1:0] b;
        do_op("u_100_7", 1'b0, 32'd100, 32'd7);
        do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("u_small_big", 1'b0, 32'd5, 32'h8000_0001);
        for (int i = 0; i < 12; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (b == '0) b = 32'd1;
            do_op("u_rand", 1'b0, $urandom, b);
        end
    endtask

    task automatic test_signed;
        logic [DW-1:0] b;
        do_op("s_m100_7", 1'b1, -32'sd100, 32'sd7);
        do_op("s_100_m7", 1'b1, 32'sd100, -32'sd7);
        do_op("s_m100_m7", 1'b1, -32'sd100, -32'sd7);
        do_op("s_min_2", 1'b1, MOST_NEG, 32'd2);
        for (int i = 0; i < 12; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
            if (b == '0) b = 32'd3;
            do_op("s_rand", 1'b1, $urandom, b);
        end
    endtask

    task automatic test_div0;
        do_op("div0_u", 1'b0, 32'h0000_1234, 32'd0);
        do_op("div0_s", 1'b1, 32'h0000_1234, 32'd0);
        do_op("div0_s_neg", 1'b1, 32'hF000_0001, 32'd0);
    endtask

    task automatic test_overflow;
        do_op("ovf_s", 1'b1, MOST_NEG, 32'hFFFF_FFFF);
        do_op("ovf_u", 1'b0, MOST_NEG, 32'hFFFF_FFFF);
        do_op("ovf_clear", 1'b1, 32'd50, 32'd5);
    endtask

    // I_VALID held high with operands changing every cycle.
    task automatic test_back_to_back;
        logic [DW-1:0]   qa[$];
        logic [DW-1:0]   qb[$];
        logic            qs[$];
        int              qc[$];
        logic [2*DW+1:0] exp;
        int              results;
        int              accepts;
        int              low_run;
        int              acc_cyc;
        logic            a_s;
        logic [DW-1:0]   a_a;
        logic [DW-1:0]   a_b;
        results = 0;
        accepts = 0;
        low_run = 0;
        valid   = 1'b1;
        for (int cyc = 0; cyc < 6 * (DW + 2) && results < 4; cyc++) begin
            sgn = 1'($urandom);
            dvd = $urandom;
            dvs = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 50)) : $urandom;
            if (ready) begin
                qs.push_back(sgn);
                qa.push_back(dvd);
                qb.push_back(dvs);
                qc.push_back(cyc);
                accepts++;
                if (accepts > 1) begin
                    total++;
                    if (low_run != DW + 1) begin
                        bad++;
                        $display("FAIL b2b_ready_low: got=%0d want=%0d", low_run, DW + 1);
                    end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                results++;
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious: O_VALID with no accept outstanding");
                end else begin
                    a_s     = qs.pop_front();
                    a_a     = qa.pop_front();
                    a_b     = qb.pop_front();
                    acc_cyc = qc.pop_front();
                    exp     = ref_div(a_s, a_a, a_b);
                    if (quot !== exp[2*DW+1:DW+2] || rem !== exp[DW+1:2] ||
                        div0 !== exp[1] || ovf !== exp[0] || cyc - acc_cyc != DW) begin
                        bad++;
                        $display("FAIL b2b_result: got q=%h r=%h d0=%b ov=%b lat=%0d want q=%h r=%h d0=%b ov=%b lat=%0d",
                                 quot, rem, div0, ovf, cyc - acc_cyc,
                                 exp[2*DW+1:DW+2], exp[DW+1:2], exp[1], exp[0], DW);
                    end
                end
            end
        end
        valid = 1'b0;
        total++;
        if (results != 4) begin
            bad++;
            $display("FAIL b2b_count: got=%0d results want=4", results);
        end
        @(posedge clk);
        #1;
    endtask

    // Reset in the 10th CALC cycle discards the operation.
    task automatic test_reset_mid;
        int spurious;
        sgn   = 1'b0;
        dvd   = 32'd1000;
        dvs   = 32'd3;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_hs: got ready=%b valid=%b want ready=1 valid=0", ready, out_valid);
        end
        total++;
        if (quot !== '0 || rem !== '0 || div0 !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_out: got q=%h r=%h d0=%b ov=%b want all 0", quot, rem, div0, ovf);
        end
        spurious = 0;
        for (int i = 0; i < DW + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL rstmid_novalid: got %0d pulses want 0", spurious);
        end
        do_op("rstmid_9_3", 1'b0, 32'd9, 32'd3);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div0();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
